// File: rtl/cim_gemm_ctrl.sv
// Sequencer for a compute-in-memory GEMM job: clears the macro's output registers,
// streams input vectors into the macro with strided addresses, then reads back 8 results.
module cim_gemm_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] row_addr,
    input  logic [7:0]  addr_stride,
    input  logic [3:0]  num_steps,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        cim_cs,
    output logic        cim_web,
    output logic        cim_cimeb,
    output logic        cim_partial_sum_eb,
    output logic        cim_reset_output_reg,
    output logic [3:0]  cim_output_reg,
    output logic [31:0] cim_address,
    output logic [31:0] cim_input_data,
    input  logic [31:0] cim_output
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPUTE,
        S_RSEL,
        S_RCAP,
        S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] addr_q, addr_nx;
    logic [7:0]  stride_q, stride_nx;
    logic [3:0]  num_q, num_nx;
    logic [31:0] data_q, data_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            num_q    <= '0;
            data_q   <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            addr_q   <= addr_nx;
            stride_q <= stride_nx;
            num_q    <= num_nx;
            data_q   <= data_nx;
        end
    end

    // One shared counter: clear-register select, accepted-step count, then result index.
    always_comb begin
        state_nx             = state;
        cnt_nx               = cnt;
        addr_nx              = addr_q;
        stride_nx            = stride_q;
        num_nx               = num_q;
        data_nx              = data_q;
        in_ready             = 1'b0;
        out_valid            = 1'b0;
        out_last             = 1'b0;
        done                 = 1'b0;
        cim_cs               = 1'b0;
        cim_web              = 1'b0;
        cim_cimeb            = 1'b0;
        cim_partial_sum_eb   = 1'b0;
        cim_reset_output_reg = 1'b0;
        cim_output_reg       = '0;
        cim_address          = '0;
        cim_input_data       = '0;
        busy                 = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_nx   = row_addr;
                    stride_nx = addr_stride;
                    num_nx    = num_steps;
                    cnt_nx    = '0;
                    state_nx  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cim_cs               = 1'b1;
                cim_cimeb            = 1'b1;
                cim_reset_output_reg = 1'b1;
                cim_output_reg       = cnt;
                if (cnt == 4'd7) begin
                    cnt_nx   = '0;
                    state_nx = (num_q == 4'd0) ? S_RSEL : S_COMPUTE;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            S_COMPUTE: begin
                cim_cs    = 1'b1;
                cim_cimeb = 1'b1;
                in_ready  = 1'b1;
                if (in_valid) begin
                    cim_partial_sum_eb = 1'b1;
                    cim_address        = addr_q;
                    cim_input_data     = in_data;
                    addr_nx            = addr_q + {24'd0, stride_q};
                    if (cnt == num_q - 4'd1) begin
                        cnt_nx   = '0;
                        state_nx = S_RSEL;
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
            end
            S_RSEL: begin
                cim_cs         = 1'b1;
                cim_cimeb      = 1'b1;
                cim_output_reg = cnt;
                data_nx        = cim_output;
                state_nx       = S_RCAP;
            end
            S_RCAP: begin
                cim_cs    = 1'b1;
                cim_cimeb = 1'b1;
                out_valid = 1'b1;
                out_last  = (cnt == 4'd7);
                if (out_ready) begin
                    if (cnt == 4'd7) begin
                        cnt_nx   = '0;
                        state_nx = S_DONE;
                    end else begin
                        cnt_nx   = cnt + 4'd1;
                        state_nx = S_RSEL;
                    end
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_cim_gemm_ctrl.sv
// Cycle-by-cycle directed and randomized jobs checked against the expected job timeline.
module tb_cim_gemm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] row_addr;
    logic [7:0]  addr_stride;
    logic [3:0]  num_steps;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        cim_cs;
    logic        cim_web;
    logic        cim_cimeb;
    logic        cim_partial_sum_eb;
    logic        cim_reset_output_reg;
    logic [3:0]  cim_output_reg;
    logic [31:0] cim_address;
    logic [31:0] cim_input_data;
    logic [31:0] cim_output;

    logic [31:0] macro_val [16];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Macro read model: selected register's value is presented for sampling at the next edge.
    assign cim_output = macro_val[cim_output_reg];

    cim_gemm_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .row_addr(row_addr),
        .addr_stride(addr_stride), .num_steps(num_steps),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done),
        .cim_cs(cim_cs), .cim_web(cim_web), .cim_cimeb(cim_cimeb),
        .cim_partial_sum_eb(cim_partial_sum_eb),
        .cim_reset_output_reg(cim_reset_output_reg),
        .cim_output_reg(cim_output_reg), .cim_address(cim_address),
        .cim_input_data(cim_input_data), .cim_output(cim_output)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({in_ready, out_valid, out_last, busy, done, cim_cs, cim_web,
                               cim_cimeb, cim_partial_sum_eb, cim_reset_output_reg,
                               cim_output_reg}), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_cim_addr"}, cim_address, 32'd0);
        chk({tag, "_cim_data"}, cim_input_data, 32'd0);
    endtask

    task automatic noise_inputs(input bit noise);
        in_data = $urandom;
        if (noise) begin
            start    = 1'($urandom);
            row_addr = $urandom;
            in_valid = 1'($urandom);
        end else begin
            start    = 1'b0;
            in_valid = 1'b0;
        end
    endtask

    // gap: idle cycles before each word after the first (-1 = random 0..2)
    task automatic run_job(input logic [31:0] row, input logic [7:0] stride, input int n,
                           input int gap, input int bp_idx, input int bp_len,
                           input bit noise, input bit fixed_data, input int abort_after);
        logic [31:0] w;
        int g;
        int stalls;
        bit stalled = 0;
        for (int i = 0; i < 16; i++) macro_val[i] = $urandom;
        start       = 1'b1;
        row_addr    = row;
        addr_stride = stride;
        num_steps   = n[3:0];
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        #1 chk("idle_busy", 32'(busy), 32'd0);
        cyc = 1;
        step();
        for (int i = 0; i < 8; i++) begin
            noise_inputs(noise);
            #1;
            chk("clr_rst_out", 32'(cim_reset_output_reg), 32'd1);
            chk("clr_out_reg", 32'(cim_output_reg), 32'(i));
            chk("clr_cs_eb", 32'({cim_cs, cim_cimeb, cim_web}), 32'b110);
            chk("clr_psum", 32'({cim_partial_sum_eb, in_ready, busy}), 32'b001);
            step();
        end
        for (int k = 0; k < n; k++) begin
            g = (k == 0) ? 0 : ((gap < 0) ? int'($urandom_range(2, 0)) : gap);
            if (g != 0) stalled = 1;
            for (int s = 0; s < g; s++) begin
                start    = noise ? 1'($urandom) : 1'b0;
                in_valid = 1'b0;
                in_data  = $urandom;
                #1;
                chk("stall_ready", 32'(in_ready), 32'd1);
                chk("stall_psum", 32'(cim_partial_sum_eb), 32'd0);
                chk("stall_data", cim_input_data, 32'd0);
                step();
            end
            w        = fixed_data ? 32'h11111111 * 32'(k + 3) : $urandom;
            start    = noise ? 1'($urandom) : 1'b0;
            in_valid = 1'b1;
            in_data  = w;
            #1;
            if (k == abort_after) begin
                rst = 1'b1;
                #1 chk_zero("rst_async");
                for (int s = 0; s < 3; s++) begin
                    step();
                    #1 chk("rst_done", 32'(done), 32'd0);
                end
                start    = 1'b0;
                in_valid = 1'b0;
                rst      = 1'b0;
                step();
                #1 chk_zero("rst_idle");
                return;
            end
            chk("cmp_ready", 32'(in_ready), 32'd1);
            chk("cmp_psum", 32'(cim_partial_sum_eb), 32'd1);
            chk("cmp_addr", cim_address, row + 32'(k) * 32'(stride));
            chk("cmp_data", cim_input_data, w);
            step();
        end
        for (int idx = 0; idx < 8; idx++) begin
            noise_inputs(noise);
            out_ready = 1'b1;
            #1;
            chk("rsel_sel", 32'(cim_output_reg), 32'(idx));
            chk("rsel_ctl", 32'({out_valid, in_ready, cim_partial_sum_eb, cim_cs}), 32'b0001);
            chk("rsel_data", cim_input_data, 32'd0);
            step();
            stalls = (idx == bp_idx) ? bp_len : 0;
            if (stalls != 0) stalled = 1;
            for (int s = 0; s <= stalls; s++) begin
                noise_inputs(noise);
                out_ready = (s == stalls);
                #1;
                chk("rcap_valid", 32'(out_valid), 32'd1);
                chk("rcap_data", out_data, macro_val[idx]);
                chk("rcap_last", 32'(out_last), 32'(idx == 7));
                chk("rcap_ready", 32'(in_ready), 32'd0);
                step();
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("done_pulse", 32'({done, busy, cim_cs, cim_cimeb, out_valid}), 32'b11000);
        if (!stalled) chk("latency", 32'(cyc), 32'(1 + 8 + n + 16 + 1));
        step();
        #1 chk("idle_after", 32'({done, busy}), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        row_addr    = '0;
        addr_stride = '0;
        num_steps   = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        for (int i = 0; i < 16; i++) macro_val[i] = $urandom;
        #2 chk_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_job(32'h0, 8'd8, 4, 0, -1, 0, 0, 1, -1);
        run_job($urandom, 8'($urandom), 3, 2, -1, 0, 0, 0, -1);
        run_job($urandom, 8'($urandom), 6, 0, 3, 5, 0, 0, -1);
        run_job($urandom, 8'($urandom), 0, 0, -1, 0, 0, 0, -1);
        run_job($urandom, 8'($urandom), 5, 0, -1, 0, 0, 0, 2);
        run_job($urandom, 8'($urandom), 4, 0, -1, 0, 0, 0, -1);
        run_job(32'hFFFFFFF8, 8'd8, 2, 0, -1, 0, 1, 0, -1);
        run_job(32'hFFFFFF00, 8'hFF, 15, 0, 7, 2, 0, 0, -1);
        for (int j = 0; j < 6; j++) begin
            run_job($urandom, 8'($urandom), int'($urandom_range(15, 0)), -1,
                    int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
                    1'($urandom), 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
